rcc_eth_clk_mode_seq: RTL

- Ethernet-side sequencer that drives the speed-select (eth_rcc_fes) and interface-select (eth_rcc_epis_2) lines into the RCC Ethernet kernel clock controller.
- Makes every mode change glitch-safe:
  - gates the MAC kernel clocks off,
  - changes the select lines,
  - waits for the RCC switch acknowledge and a settle time,
  - re-enables the clocks.
- Sits between the ETH configuration register block and the RCC, in the ETH register clock domain.

---
 rtl/rcc_eth_clk_mode_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rcc_eth_clk_mode_seq.sv
// Glitch-safe sequencer for the RCC Ethernet kernel clock mode selects.
// Each mode change gates the MAC clocks off, switches the selects, waits for the ack and a settle time, then re-opens the gate.
module rcc_eth_clk_mode_seq #(
   parameter int GATE_WAIT  = 4,
   parameter int SETTLE_CYC = 8,
   parameter int TIMEOUT    = 256,
   parameter int CW         = 9
) (
   input  logic clk,
   input  logic rst_n,
   input  logic cfg_req,
   input  logic cfg_fes,
   input  logic cfg_epis_2,
   output logic cfg_busy,
   output logic cfg_done,
   output logic cfg_err,
   output logic eth_rcc_fes,
   output logic eth_rcc_epis_2,
   output logic eth_clk_gate_en,
   input  logic rcc_eth_sw_ack
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GATE_OFF,
      S_SWITCH,
      S_SETTLE,
      S_GATE_ON
   } state_t;

   localparam logic [CW-1:0] C_GATE_LD   = CW'(GATE_WAIT - 1);
   localparam logic [CW-1:0] C_SETTLE_LD = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] C_TO_LD     = CW'(TIMEOUT - 1);

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_ack_q;
   logic          r_pending, w_pending_nxt;
   logic [1:0]    r_pend_mode, w_pend_mode_nxt;
   logic [1:0]    r_new_mode, w_new_mode_nxt;
   logic [1:0]    r_old_mode, w_old_mode_nxt;
   logic [1:0]    r_sel, w_sel_nxt;
   logic          r_gate, w_gate_nxt;
   logic          r_busy, w_busy_nxt;
   logic          r_done, w_done_nxt;
   logic          r_err, w_err_nxt;
   logic          w_ack_rise;
   logic          w_cnt_zero;
   logic [1:0]    w_req_mode;
   logic [1:0]    w_target;

   // Only a fresh rising edge counts, so a level left high from an earlier switch is never taken as an ack.
   assign w_ack_rise = rcc_eth_sw_ack & ~r_ack_q;
   assign w_cnt_zero = (r_cnt == '0);
   assign w_req_mode = {cfg_fes, cfg_epis_2};
   assign w_target   = r_pending ? r_pend_mode : w_req_mode;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_ack_q     <= 1'b0;
         r_pending   <= 1'b0;
         r_pend_mode <= 2'b00;
         r_new_mode  <= 2'b00;
         r_old_mode  <= 2'b00;
         r_sel       <= 2'b00;
         r_gate      <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_ack_q     <= rcc_eth_sw_ack;
         r_pending   <= w_pending_nxt;
         r_pend_mode <= w_pend_mode_nxt;
         r_new_mode  <= w_new_mode_nxt;
         r_old_mode  <= w_old_mode_nxt;
         r_sel       <= w_sel_nxt;
         r_gate      <= w_gate_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_err       <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_pending_nxt   = r_pending;
      w_pend_mode_nxt = r_pend_mode;
      w_new_mode_nxt  = r_new_mode;
      w_old_mode_nxt  = r_old_mode;
      w_sel_nxt       = r_sel;
      w_gate_nxt      = r_gate;
      w_busy_nxt      = r_busy;
      w_done_nxt      = 1'b0;
      w_err_nxt       = r_err;

      // One-deep, last-wins holding slot for requests arriving mid-sequence.
      if (cfg_req && r_busy) begin
         w_pending_nxt   = 1'b1;
         w_pend_mode_nxt = w_req_mode;
      end

      case (r_state)
         S_IDLE: begin
            if (r_pending || cfg_req) begin
               w_pending_nxt   = r_pending & cfg_req;
               w_pend_mode_nxt = (r_pending & cfg_req) ? w_req_mode : r_pend_mode;
               w_err_nxt       = 1'b0;
               if (w_target == r_sel) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_new_mode_nxt = w_target;
                  w_old_mode_nxt = r_sel;
                  w_gate_nxt     = 1'b0;
                  w_busy_nxt     = 1'b1;
                  w_cnt_nxt      = C_GATE_LD;
                  w_state_nxt    = S_GATE_OFF;
               end
            end
         end
         S_GATE_OFF: begin
            if (w_cnt_zero) begin
               w_sel_nxt   = r_new_mode;
               w_cnt_nxt   = C_TO_LD;
               w_state_nxt = S_SWITCH;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         S_SWITCH: begin
            if (w_ack_rise) begin
               w_cnt_nxt   = C_SETTLE_LD;
               w_state_nxt = S_SETTLE;
            end else if (w_cnt_zero) begin
               w_sel_nxt   = r_old_mode;
               w_err_nxt   = 1'b1;
               w_cnt_nxt   = C_SETTLE_LD;
               w_state_nxt = S_SETTLE;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         S_SETTLE: begin
            if (w_cnt_zero) begin
               w_gate_nxt  = 1'b1;
               w_done_nxt  = 1'b1;
               w_state_nxt = S_GATE_ON;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         S_GATE_ON: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign cfg_busy        = r_busy;
   assign cfg_done        = r_done;
   assign cfg_err         = r_err;
   assign eth_rcc_fes     = r_sel[1];
   assign eth_rcc_epis_2  = r_sel[0];
   assign eth_clk_gate_en = r_gate;

endmodule
